prog_loader: RTL and testbench
==============================

# prog_loader

Writes instruction words into the processor's instruction memory from a byte stream, filling the memory that the fetch stage later reads by address. It sits between a host byte source (testbench or UART front end) and the instruction memory's write port. It packs two bytes into each 9-bit word, writes the words to consecutive addresses from 0, and reports completion or a protocol error. The core stays in reset until the loader reports done.

## Interface

**Parameters**
- A, 10: number of instruction-memory address bits; memory depth is 2**A words.
- W, 9: instruction width. The byte packing below is fixed for W=9; other values are unsupported.

**Ports**
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- ByteIn  input  8  stream data byte.
- ByteValid  input  1  ByteIn is valid this cycle.
- ByteReady  output  1  loader accepts a byte this cycle.
- WrEn  output  1  instruction-memory write strobe, one cycle per word.
- WrAddr  output  A  write address.
- WrData  output  W  write data.
- Busy  output  1  a load is in progress.
- Done  output  1  load completed cleanly; sticky until the next Start or Reset.
- Error  output  1  protocol error; sticky until the next Start or Reset.
- Count  output  A+1  number of words written in the current or last load.

## Operation

**Word format:** two bytes per instruction, low byte first.
- Byte 0: WrData[7:0].
- Byte 1, bit 0: WrData[8].
- Byte 1, bit 7: LAST flag, marks the final word.
- Byte 1, bits 6:1: must be 0; a nonzero value is an error.

**Handshake:** a byte transfers on a rising edge where ByteValid && ByteReady. ByteReady is a function of state only and never depends on ByteValid.

**FSM states:** IDLE, LO, HI, WRITE, DONE, ERR.
- IDLE: ByteReady=0. Start → LO; clears Count, write pointer, Done and Error.
- LO: ByteReady=1. On a transfer, latch the low byte → HI.
- HI: ByteReady=1. On a transfer:
  - bits 6:1 nonzero → ERR, with no write.
  - otherwise latch bit 0 and LAST → WRITE.
- WRITE: ByteReady=0 and WrEn=1 for exactly this cycle, with WrAddr = pointer and WrData = {bit8, low byte}.
  - Next edge: pointer+1 and Count+1.
  - If LAST → DONE.
  - Else if the pointer was 2**A-1 (memory full, no LAST seen) → ERR.
  - Else → LO.
- DONE: Done=1. Start → LO with a fresh load.
- ERR: Error=1. Start → LO with a fresh load.

**Other rules**
- Start is ignored in LO, HI and WRITE.
- Busy=1 in LO, HI and WRITE.
- Words already written before an error stay in memory; the loader never clears memory.
- WrAddr always equals the write pointer. WrData holds the last assembled word when WrEn=0.
- Count saturates naturally at 2**A, since a full memory forces DONE or ERR.

## Timing

**Reset values:** state IDLE, ByteReady=0, WrEn=0, WrAddr=0, WrData=0, Busy=0, Done=0, Error=0, Count=0.
- Reset is asynchronous. Asserting it mid-load aborts immediately: WrEn drops at once and no partial word is written.

**Throughput and latency**
- Minimum of 3 cycles per word: LO, HI, WRITE.
- WrEn rises the cycle after the byte-1 transfer edge.
- Done or Error rises the cycle after the WRITE (or HI-error) edge.

**Boundary cases**
- Idle gaps (ByteValid=0) in LO or HI are allowed indefinitely; state and data are held.
- A word with LAST set at address 2**A-1 is written → DONE (Count=2**A), not ERR.
- ByteValid while in IDLE, WRITE, DONE or ERR: the byte is not consumed (ByteReady=0).
- Start and ByteValid in the same IDLE cycle: only Start acts; the first byte is accepted in LO on a later edge.

## Test plan

- **Basic load:** Start, then bytes 0x0C,0x00, 0x28,0x00, 0xAA,0x81. Required: three WrEn pulses at addresses 0,1,2 with data 0x00C, 0x028, 0x1AA; then Done=1, Count=3, Busy=0.
- **Backpressure and gaps:** the same stream with ByteValid dropped for 5 cycles between every byte. Required: identical writes; ByteReady=0 during WRITE cycles; no byte lost or duplicated.
- **Malformed byte 1:** Start, then 0x55,0x02. Required: no WrEn; Error=1, Done=0, Count=0. A following Start with a valid stream loads normally from address 0.
- **Overflow, A=2:** send 4 words, none with LAST. Required: writes at addresses 0–3, then Error=1, Count=4. Repeat with LAST on word 4: Done=1, Count=4.
- **Reset mid-load:** assert Reset asynchronously (between clock edges) while in HI after 2 words. Required: all outputs go to their reset values at once; no third write; Count=0.
- **Restart from DONE:** Start, then one word 0xFF,0x81. Required: WrAddr=0, WrData=0x1FF, Count=1, Done=1. Start while Busy is ignored (inject it in LO; Count is unaffected).

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Bundles the loader's host byte stream, instruction-memory write port and
//   status signals so they travel as one port.
//   Parameters: A = instruction-memory address bits, W = instruction width.
//   Signals:
//     start                  - one-cycle pulse that begins a load
//     byte_in/byte_valid     - host byte stream (host drives)
//     byte_ready             - loader accepts a byte this cycle
//     wr_en/wr_addr/wr_data  - instruction-memory write port
//     busy/done/error/count  - load status
//   Modports: slave = the loader, master = the host/bench side.
interface prog_loader_if #(
  parameter int A = 10,
  parameter int W = 9
);
  logic         start;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         error;
  logic [A:0]   count;

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, error, count
  );

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error, count
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader
//   Fills the instruction memory from a byte stream. Two bytes form one 9-bit
//   word (low byte first; second byte carries bit 8 in bit 0 and a LAST flag
//   in bit 7, bits 6:1 must be zero). Words go to consecutive addresses from
//   0; the load ends in DONE on a LAST word or in ERR on a malformed second
//   byte or when memory fills without LAST.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - prog_loader_if.slave (stream in, memory write port, status out)
module prog_loader #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LO    = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]   state;
  logic [7:0]   low_byte;
  logic         last_flag;
  logic [A-1:0] ptr;
  logic [A:0]   count;
  logic [W-1:0] wr_data_q;
  logic         xfer;

  // Ready depends on state alone, so a transfer is simply valid && ready.
  assign xfer = bus.byte_valid && bus.byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      low_byte  <= '0;
      last_flag <= 1'b0;
      ptr       <= '0;
      count     <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            state <= S_LO;
            ptr   <= '0;
            count <= '0;
          end
        end
        S_LO: begin
          if (xfer) begin
            low_byte <= bus.byte_in;
            state    <= S_HI;
          end
        end
        S_HI: begin
          if (xfer) begin
            // Reserved bits set: abort without writing this word.
            if (bus.byte_in[6:1] != 6'd0) begin
              state <= S_ERR;
            end else begin
              wr_data_q <= {bus.byte_in[0], low_byte};
              last_flag <= bus.byte_in[7];
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // ptr wraps to 0 after the last address, but the FSM always leaves
          // for DONE or ERR in that case, so the wrapped value is never used.
          ptr   <= ptr + 1'b1;
          count <= count + 1'b1;
          if (last_flag)
            state <= S_DONE;
          else if (ptr == '1)
            state <= S_ERR;
          else
            state <= S_LO;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them
  // immediately and a write can never be issued from a partial word.
  assign bus.byte_ready = (state == S_LO) || (state == S_HI);
  assign bus.wr_en      = (state == S_WRITE);
  assign bus.busy       = (state == S_LO) || (state == S_HI) || (state == S_WRITE);
  assign bus.done       = (state == S_DONE);
  assign bus.error      = (state == S_ERR);
  assign bus.wr_addr    = ptr;
  assign bus.wr_data    = wr_data_q;
  assign bus.count      = count;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
//   Self-checking bench for prog_loader with a 4-word memory (A=2) so that
//   overflow and LAST-at-full cases are reachable. Expected writes come from
//   a reference model that walks the byte stream word by word; a monitor pops
//   them whenever the loader strobes wr_en.
module tb_prog_loader;
  localparam int A     = 2;
  localparam int W     = 9;
  localparam int DEPTH = 1 << A;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  wr_t  exp_q[$];
  wr_t  got;
  logic [7:0] stim[$];

  prog_loader_if #(.A(A), .W(W)) bus ();

  prog_loader #(.A(A), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_write_addr", 32'(bus.wr_addr), 32'hFFFF_FFFF);
      end else begin
        got = exp_q.pop_front();
        check_output("write_addr", 32'(bus.wr_addr), 32'(got.addr));
        check_output("write_data", 32'(bus.wr_data), 32'(got.data));
        check_output("ready_in_write", 32'(bus.byte_ready), 32'd0);
      end
    end
  end

  // Reference model: words are consumed pairwise; pushes the expected writes
  // and reports how many bytes the loader will actually take.
  task automatic model_load(output int n_use, output bit e_done, output bit e_err,
                            output int e_count, output bit last_write,
                            output logic [W-1:0] last_data);
    int words;
    logic [7:0] lo;
    logic [7:0] hi;
    words = 0; n_use = 0; e_done = 0; e_err = 0; last_write = 0; last_data = '0;
    for (int i = 0; i + 1 < stim.size(); i += 2) begin
      lo    = stim[i];
      hi    = stim[i+1];
      n_use = i + 2;
      if (hi[6:1] != 6'd0) begin
        e_err = 1; last_write = 0;
        break;
      end
      last_data = {hi[0], lo};
      exp_q.push_back(wr_t'{addr: A'(words), data: last_data});
      words++;
      last_write = 1;
      if (hi[7]) begin e_done = 1; break; end
      if (words == DEPTH) begin e_err = 1; break; end
    end
    e_count = words;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    bus.byte_valid = 1'b0;
    check_output("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic apply_stimulus(input string name, input bit start_with_valid,
                                input int gap_min, input int gap_max, input bit start_in_lo);
    int n_use, e_count, gap;
    bit e_done, e_err, last_write;
    logic [W-1:0] last_data;
    model_load(n_use, e_done, e_err, e_count, last_write, last_data);
    $display("[TB] load %s: %0d bytes", name, n_use);
    bus.start = 1'b1;
    if (start_with_valid) begin
      bus.byte_valid = 1'b1;
      bus.byte_in    = stim[0];
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_output({name, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    check_output({name, "_count_cleared"}, 32'(bus.count), 32'd0);
    if (start_in_lo) begin
      bus.byte_valid = 1'b0;
      bus.start      = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_output({name, "_start_ignored_in_lo"}, 32'(bus.busy), 32'd1);
    end
    for (int i = 0; i < n_use; i++) begin
      send_byte(stim[i]);
      if (i != n_use - 1) begin
        gap = $urandom_range(gap_min, gap_max);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
      end
    end
    @(negedge clk);
    if (last_write) begin
      check_output({name, "_wr_en_latency"}, 32'(bus.wr_en), 32'd1);
      @(negedge clk);
    end else begin
      check_output({name, "_no_write_on_error"}, 32'(bus.wr_en), 32'd0);
    end
    check_output({name, "_done"}, 32'(bus.done), 32'(e_done));
    check_output({name, "_error"}, 32'(bus.error), 32'(e_err));
    check_output({name, "_count"}, 32'(bus.count), 32'(e_count));
    check_output({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    check_output({name, "_ready_end"}, 32'(bus.byte_ready), 32'd0);
    check_output({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    if (last_write)
      check_output({name, "_wr_data_held"}, 32'(bus.wr_data), 32'(last_data));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string name);
    check_output({name, "_wr_en"},   32'(bus.wr_en),      32'd0);
    check_output({name, "_wr_addr"}, 32'(bus.wr_addr),    32'd0);
    check_output({name, "_wr_data"}, 32'(bus.wr_data),    32'd0);
    check_output({name, "_busy"},    32'(bus.busy),       32'd0);
    check_output({name, "_done"},    32'(bus.done),       32'd0);
    check_output({name, "_error"},   32'(bus.error),      32'd0);
    check_output({name, "_count"},   32'(bus.count),      32'd0);
    check_output({name, "_ready"},   32'(bus.byte_ready), 32'd0);
  endtask

  task automatic set_stim(input logic [7:0] b[]);
    stim.delete();
    foreach (b[i]) stim.push_back(b[i]);
  endtask

  task automatic random_stream();
    int k;
    logic [7:0] hi;
    stim.delete();
    k = $urandom_range(1, DEPTH + 1);
    for (int w = 0; w < DEPTH + 1; w++) begin
      hi = {(w + 1 == k), 6'd0, 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 7) == 0) hi[6:1] = 6'($urandom_range(1, 63));
      stim.push_back(8'($urandom_range(0, 255)));
      stim.push_back(hi);
    end
  endtask

  initial begin
    int n_use, e_count;
    bit e_done, e_err, last_write;
    logic [W-1:0] last_data;
    checks = 0;
    errors = 0;
    bus.start      = 1'b0;
    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    #3;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    set_stim('{8'h0C, 8'h00, 8'h28, 8'h00, 8'hAA, 8'h81});
    apply_stimulus("basic", 0, 0, 0, 0);
    set_stim('{8'h0C, 8'h00, 8'h28, 8'h00, 8'hAA, 8'h81});
    apply_stimulus("gaps", 0, 5, 5, 0);
    set_stim('{8'h55, 8'h02});
    apply_stimulus("malformed", 0, 0, 0, 0);
    set_stim('{8'h0C, 8'h00, 8'h28, 8'h00, 8'hAA, 8'h81});
    apply_stimulus("after_error", 1, 0, 2, 0);
    set_stim('{8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'h00, 8'h04, 8'h01});
    apply_stimulus("overflow", 0, 0, 1, 0);
    set_stim('{8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'h00, 8'h04, 8'h81});
    apply_stimulus("last_at_full", 0, 0, 1, 0);
    set_stim('{8'hFF, 8'h81});
    apply_stimulus("restart_done", 0, 0, 0, 1);

    // Reset between edges while the third word's second byte is pending.
    $display("[TB] load reset_mid_load");
    set_stim('{8'h11, 8'h00, 8'h22, 8'h01, 8'h33, 8'h80});
    model_load(n_use, e_done, e_err, e_count, last_write, last_data);
    void'(exp_q.pop_back());
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(stim[i]);
    #2 rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    check_output("mid_reset_writes_done", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check_output("mid_reset_stays_idle", 32'(bus.busy), 32'd0);
    exp_q.delete();

    for (int t = 0; t < 30; t++) begin
      random_stream();
      apply_stimulus($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 0, 3,
                     1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
